// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, the port-select codes and the counter width.
package mem_arb_pkg;

    // Arbiter FSM: one transaction is in flight from ISSUE through RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Winner encoding, also used for the round-robin last-grant bit.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    // Latency counter width; the read latency never exceeds 4.
    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between fetch and data ports.
// Optional round-robin tie-break is built when MEM_ARB_RR_EN is defined.
//
// Ports:
//   i_req_i  - instruction fetch request
//   d_req_i  - data request
//   last_i   - last granted port (only present with MEM_ARB_RR_EN)
//   req_o    - at least one request pending
//   sel_o    - selected port (SEL_I / SEL_D), meaningful when req_o is high
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic req_o,
    output logic sel_o
);

    assign req_o = i_req_i | d_req_i;

    always_comb begin
        sel_o = SEL_D;
        if (i_req_i && !d_req_i) begin
            sel_o = SEL_I;
        end
`ifdef MEM_ARB_RR_EN
        // Tie: hand the grant to the port that did not win last time.
        else if (i_req_i && d_req_i) begin
            sel_o = ~last_i;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port and
// the load/store port, one transaction at a time, all outputs registered.
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (read latency 1..4).
// Ports:
//   clk, rst                    - clock, async active-high reset
//   i_req, i_addr               - fetch request (read only)
//   i_gnt, i_rvalid, i_rdata    - fetch grant pulse, data pulse, data
//   d_req, d_we, d_addr, d_wdata- data request
//   d_gnt, d_rvalid, d_rdata    - data grant pulse, completion pulse, data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata        - memory port
// Build option: MEM_ARB_RR_EN selects round-robin tie-break instead of
// fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               we_q, we_d;

    logic               i_gnt_q, i_gnt_d;
    logic               d_gnt_q, d_gnt_d;
    logic               i_rvalid_q, i_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               pick_req;
    logic               pick_sel;
    logic [CNT_W-1:0]   cnt_dec;

`ifdef MEM_ARB_RR_EN
    logic               last_q, last_d;
`endif

    mem_arb_pick u_pick (
        .i_req_i (i_req),
        .d_req_i (d_req),
`ifdef MEM_ARB_RR_EN
        .last_i  (last_q),
`endif
        .req_o   (pick_req),
        .sel_o   (pick_sel)
    );

    assign cnt_dec = cnt_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        we_d        = we_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Grant and strobe are registered here so they are
                // visible for exactly the ISSUE cycle.
                if (pick_req) begin
                    state_d  = ISSUE;
                    sel_d    = pick_sel;
                    mem_en_d = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_d   = pick_sel;
`endif
                    if (pick_sel == SEL_D) begin
                        d_gnt_d     = 1'b1;
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        i_gnt_d     = 1'b1;
                        we_d        = 1'b0;
                        mem_addr_d  = i_addr;
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT;
                cnt_d   = LAT_CNT;
            end

            WAIT: begin
                // Read data is sampled on the edge where the count
                // would reach zero, i.e. MEM_LAT cycles after mem_en.
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = RESP;
                    if (sel_q == SEL_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = we_q ? '0 : mem_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= SEL_D;
            we_q        <= 1'b0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= SEL_D;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
